// File: rtl/line_mem_ctrl.sv
// line_mem_ctrl: line-granular main-memory model serving the I- and D-caches.
// One outstanding access with a fixed LATENCY. Lines are 4 x 32-bit words.
// The backing store 'data' is never cleared by reset.
// Optional build macro MEM_ARB_RR_EN selects round-robin arbitration between
// the ports. When it is undefined, arbitration is fixed priority with D over I.
//
// state  | meaning
// S_IDLE | ready to accept; readies follow arbitration
// S_BUSY | access in flight, counter runs down to 0
// S_RESP | one-cycle response; a write commits at the end of this cycle
module line_mem_ctrl #(
    parameter int MEM_WORDS = 8192,
    parameter int LATENCY   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_req_valid,
    input  logic [31:0]  i_req_addr,
    output logic         i_req_ready,
    output logic         i_resp_valid,
    output logic [127:0] i_resp_data,
    input  logic         d_req_valid,
    input  logic         d_req_write,
    input  logic [31:0]  d_req_addr,
    input  logic [127:0] d_req_wdata,
    output logic         d_req_ready,
    output logic         d_resp_valid,
    output logic [127:0] d_resp_data
);
    localparam int AW       = $clog2(MEM_WORDS);
    localparam int LW       = AW - 2;
    localparam int CW       = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam int LOAD_INT = (LATENCY >= 2) ? LATENCY - 2 : 0;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LOAD_INT);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    logic [31:0] data [MEM_WORDS];

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            port_q, port_d;      // 1 = D port owns the access
    logic            write_q, write_d;
    logic [LW-1:0]   line_q, line_d;
    logic [127:0]    wdata_q, wdata_d;

    logic idle, d_prio, grant_i, grant_d, acc_i, acc_d;
    logic [127:0] rd_line, resp_line;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;                 // 1 = D was granted last

    // Round-robin: remember which port was granted most recently
    always_ff @(posedge clk) begin
        if (rst) last_q <= 1'b0;
        else     last_q <= last_d;
    end

    assign last_d = acc_d ? 1'b1 : (acc_i ? 1'b0 : last_q);
    assign d_prio = ~last_q;
`else
    assign d_prio = 1'b1;
`endif

    // A port loses only when both request and the other one has priority;
    // with no conflict the single requester (or nobody) sees ready in IDLE.
    assign idle        = (state_q == S_IDLE);
    assign grant_i     = i_req_valid & ~(d_req_valid & d_prio);
    assign grant_d     = d_req_valid & ~(i_req_valid & ~d_prio);
    assign i_req_ready = idle & ~grant_d;
    assign d_req_ready = idle & ~grant_i;
    assign acc_i       = i_req_valid & i_req_ready;
    assign acc_d       = d_req_valid & d_req_ready;

    // State and latency counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: BUSY lasts LATENCY-1 cycles, skipped entirely when LATENCY=1
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (acc_i | acc_d) begin
                    state_d = (LATENCY == 1) ? S_RESP : S_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) state_d = S_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request fields are captured only at accept and held for the whole access
    always_ff @(posedge clk) begin
        if (rst) begin
            port_q  <= 1'b0;
            write_q <= 1'b0;
            line_q  <= '0;
            wdata_q <= '0;
        end else begin
            port_q  <= port_d;
            write_q <= write_d;
            line_q  <= line_d;
            wdata_q <= wdata_d;
        end
    end

    // Select the accepted request's fields; upper address bits wrap away
    always_comb begin
        port_d  = port_q;
        write_d = write_q;
        line_d  = line_q;
        wdata_d = wdata_q;
        if (acc_d) begin
            port_d  = 1'b1;
            write_d = d_req_write;
            line_d  = d_req_addr[AW+1:4];
            wdata_d = d_req_wdata;
        end else if (acc_i) begin
            port_d  = 1'b0;
            write_d = 1'b0;
            line_d  = i_req_addr[AW+1:4];
        end
    end

    // Write commit happens only at the end of RESP, so a reset during BUSY drops it
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_RESP && write_q) begin
            for (int k = 0; k < 4; k++) begin
                data[{line_q, 2'(k)}] <= wdata_q[32*k +: 32];
            end
        end
    end

    // Response outputs: line read at response time, zero outside RESP
    always_comb begin
        rd_line      = {data[{line_q, 2'd3}], data[{line_q, 2'd2}],
                        data[{line_q, 2'd1}], data[{line_q, 2'd0}]};
        resp_line    = write_q ? wdata_q : rd_line;
        i_resp_valid = (state_q == S_RESP) & ~port_q;
        d_resp_valid = (state_q == S_RESP) & port_q;
        i_resp_data  = i_resp_valid ? resp_line : '0;
        d_resp_data  = d_resp_valid ? resp_line : '0;
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_req_addr[31:AW+2], i_req_addr[3:0],
                                d_req_addr[31:AW+2], d_req_addr[3:0]};
endmodule
